// File: rtl/pit_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// pit_irq_ctrl_if
// Register bus between a host and the interval-timer interrupt controller.
//   cs     chip select
//   rd     read strobe (no side effects)
//   wr     write strobe, one write per clk while cs=1
//   a      register address (0 STATUS, 1 MASK, 2 POL, 3 COUNT)
//   idata  write data
//   odata  read data, combinational, 0 unless cs & rd
// master: host side, slave: controller side.
// -----------------------------------------------------------------------------
interface pit_irq_ctrl_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [1:0] a;
    logic [7:0] idata;
    logic [7:0] odata;

    modport master (output cs, rd, wr, a, idata, input odata);
    modport slave  (input cs, rd, wr, a, idata, output odata);
endinterface

// File: rtl/pit_irq_ctrl.sv
// -----------------------------------------------------------------------------
// pit_irq_ctrl
// Edge-detecting interrupt controller for the three outputs of an interval
// timer. Each channel is synchronized, edge-detected with a programmable
// polarity, latched into PEND/OVR status bits and counted in a saturating
// event counter. irq is the registered OR of the unmasked pending bits.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   tout   timer outputs out2..out0, asynchronous to clk
//   bus    register bus (slave side), see pit_irq_ctrl_if
//   irq    registered interrupt request, active high
// -----------------------------------------------------------------------------
module pit_irq_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         tout,
    pit_irq_ctrl_if.slave      bus,
    output logic               irq
);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_POL    = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_s1;
    logic [2:0]       r_s2;
    logic [2:0]       r_s3;
    logic [1:0]       r_arm_cnt;
    logic [2:0]       r_pend;
    logic [2:0]       r_ovr;
    logic [2:0]       r_mask;
    logic [2:0]       r_pol;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_cnt [3];
    logic             r_irq;

    logic             w_wr;
    logic             w_wr_status;
    logic             w_wr_mask;
    logic             w_wr_pol;
    logic             w_wr_count;
    logic             w_armed;
    logic [2:0]       w_evt;
    logic [2:0]       w_pend_clr;
    logic [2:0]       w_ovr_clr;
    logic [2:0]       w_pend_nxt;
    logic [2:0]       w_ovr_nxt;
    logic             w_cnt_clr;
    logic [1:0]       w_sel_nxt;
    logic [CNT_W-1:0] w_cnt_sel;
    logic [7:0]       w_rdata;
    logic             w_unused;

    assign w_wr        = bus.cs & bus.wr;
    assign w_wr_status = w_wr & (bus.a == ADDR_STATUS);
    assign w_wr_mask   = w_wr & (bus.a == ADDR_MASK);
    assign w_wr_pol    = w_wr & (bus.a == ADDR_POL);
    assign w_wr_count  = w_wr & (bus.a == ADDR_COUNT);

    // Arm timer counts down from 3 after reset; a timer output that is
    // already high at reset reaches s2 before s3 and would otherwise look
    // like a rising edge on the third edge.
    assign w_armed = (r_arm_cnt == 2'd0);

    assign w_evt = {3{w_armed}} &
                   ((r_s2 & ~r_s3 & ~r_pol) | (~r_s2 & r_s3 & r_pol));

    assign w_pend_clr = w_wr_status ? bus.idata[2:0] : 3'b000;
    assign w_ovr_clr  = w_wr_status ? bus.idata[6:4] : 3'b000;

    // An event beats a same-cycle clear of its PEND bit, and because the
    // host has just acknowledged that bit it is not counted as an overrun.
    assign w_pend_nxt = w_evt | (r_pend & ~w_pend_clr);
    assign w_ovr_nxt  = (r_ovr & ~w_ovr_clr) | (w_evt & r_pend & ~w_pend_clr);

    assign w_cnt_clr = w_wr_count & bus.idata[7];
    assign w_sel_nxt = (bus.idata[1:0] == 2'd3) ? 2'd0 : bus.idata[1:0];

    assign w_unused = bus.idata[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 3'b000;
            r_s2      <= 3'b000;
            r_s3      <= 3'b000;
            r_arm_cnt <= 2'd3;
        end else begin
            r_s1 <= tout;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 3'b000;
            r_ovr  <= 3'b000;
            r_mask <= 3'b000;
            r_pol  <= 3'b000;
            r_sel  <= 2'd0;
            r_irq  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ovr  <= w_ovr_nxt;
            if (w_wr_mask) begin
                r_mask <= bus.idata[2:0];
            end
            if (w_wr_pol) begin
                r_pol <= bus.idata[2:0];
            end
            if (w_wr_count) begin
                r_sel <= w_sel_nxt;
            end
            r_irq <= |(r_pend & r_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_cnt_clr) begin
                    r_cnt[i] <= '0;
                end else if (w_evt[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        w_cnt_sel = r_cnt[0];
        case (r_sel)
            2'd1:    w_cnt_sel = r_cnt[1];
            2'd2:    w_cnt_sel = r_cnt[2];
            default: w_cnt_sel = r_cnt[0];
        endcase
    end

    always_comb begin
        w_rdata = 8'h00;
        if (bus.cs && bus.rd) begin
            case (bus.a)
                ADDR_STATUS: w_rdata = {1'b0, r_ovr, 1'b0, r_pend};
                ADDR_MASK:   w_rdata = {5'b00000, r_mask};
                ADDR_POL:    w_rdata = {5'b00000, r_pol};
                default:     w_rdata = 8'(w_cnt_sel);
            endcase
        end
    end

    assign bus.odata = w_rdata;
    assign irq       = r_irq;

endmodule
